// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with flush/branch
// redirect and a circular return-address stack.
module pc_gen #(
  parameter int unsigned XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned INC       = 4,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_inc;
  logic            valid_q;
  logic [PW-1:0]   top_q;
  logic [PW-1:0]   top_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic            adv;
  logic            ras_empty;
  logic            ras_full;
  logic            do_push;
  logic            do_pop;

  assign adv       = start_i & ~hold_i;
  assign pc_inc    = pc_q + XLEN'(INC);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);

  // A flush owns the cycle: no call push, no return pop.
  assign do_push = adv & ~flush_i & branch_i & call_i;
  assign do_pop  = adv & ~flush_i & ~branch_i
                 & ret_i & ~ras_empty;

  // Next-PC select, highest priority first.
  always_comb begin
    pc_d = pc_q;
    if (!start_i) begin
      pc_d = pc_q;
    end else if (flush_i) begin
      pc_d = flush_pc_i;
    end else if (hold_i) begin
      pc_d = pc_q;
    end else if (branch_i) begin
      pc_d = branch_pc_i;
    end else if (do_pop) begin
      pc_d = ras_q[top_q];
    end else begin
      pc_d = pc_inc;
    end
  end

  // Stack pointer/count next state; a full push wraps
  // onto the oldest entry and keeps the count saturated.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (do_push) begin
      top_d = top_q + PTR_ONE;
      if (!ras_full) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (do_pop) begin
      top_d = top_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // PC, valid flag and stack control registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= start_i;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stack storage; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      ras_q[top_d] <= pc_inc;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid_q;
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed checks of the fetch PC
// generator and its return-address stack.
module tb_pc_gen;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        hold_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_pc_i = '0;
  logic        call_i = 1'b0;
  logic        ret_i = 1'b0;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        ras_empty_o;
  logic        ras_full_o;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .flush_pc_i  (flush_pc_i),
    .branch_i    (branch_i),
    .branch_pc_i (branch_pc_i),
    .call_i      (call_i),
    .ret_i       (ret_i),
    .pc_o        (pc_o),
    .pc_valid_o  (pc_valid_o),
    .ras_empty_o (ras_empty_o),
    .ras_full_o  (ras_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    hold_i   = 1'b0;
    flush_i  = 1'b0;
    branch_i = 1'b0;
    call_i   = 1'b0;
    ret_i    = 1'b0;
  endtask

  task automatic do_call(input logic [31:0] tgt);
    branch_i    = 1'b1;
    call_i      = 1'b1;
    branch_pc_i = tgt;
    step();
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    flush_i    = 1'b1;
    flush_pc_i = tgt;
    step();
  endtask

  initial begin
    #3;
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", 32'(pc_valid_o), 32'h0);
    check("rst_empty", 32'(ras_empty_o), 32'h1);
    check("rst_full", 32'(ras_full_o), 32'h0);
    rst_i = 1'b1;
    step();
    check("idle_pc", pc_o, 32'h0);
    check("idle_valid", 32'(pc_valid_o), 32'h0);

    start_i = 1'b1;
    step();
    check("seq1", pc_o, 32'h4);
    check("seq1_valid", 32'(pc_valid_o), 32'h1);
    step();
    check("seq2", pc_o, 32'h8);
    step();
    check("seq3", pc_o, 32'hC);
    step();
    check("seq4", pc_o, 32'h10);

    hold_i = 1'b1;
    step();
    check("hold1", pc_o, 32'h10);
    check("hold_valid", 32'(pc_valid_o), 32'h1);
    hold_i = 1'b1;
    step();
    check("hold2", pc_o, 32'h10);
    hold_i = 1'b1;
    do_flush(32'h200);
    check("flush_hold", pc_o, 32'h200);

    start_i = 1'b0;
    step();
    check("stop_pc", pc_o, 32'h200);
    check("stop_valid", 32'(pc_valid_o), 32'h0);
    start_i = 1'b1;

    call_i = 1'b1;
    step();
    check("call_nobr_pc", pc_o, 32'h204);
    check("call_nobr_empty",
          32'(ras_empty_o), 32'h1);

    do_flush(32'h40);
    check("fl40", pc_o, 32'h40);
    do_call(32'h100);
    check("call_pc", pc_o, 32'h100);
    check("call_empty", 32'(ras_empty_o), 32'h0);
    step();
    check("callee", pc_o, 32'h104);
    ret_i = 1'b1;
    step();
    check("ret_pc", pc_o, 32'h44);
    check("ret_empty", 32'(ras_empty_o), 32'h1);

    do_flush(32'h0);
    check("fl0", pc_o, 32'h0);
    do_call(32'h10);
    do_call(32'h20);
    do_call(32'h30);
    check("n3_full", 32'(ras_full_o), 32'h0);
    do_call(32'h40);
    check("n4_pc", pc_o, 32'h40);
    check("n4_full", 32'(ras_full_o), 32'h1);
    do_call(32'h50);
    check("n5_pc", pc_o, 32'h50);
    check("n5_full", 32'(ras_full_o), 32'h1);
    ret_i = 1'b1;
    step();
    check("r1", pc_o, 32'h44);
    check("r1_full", 32'(ras_full_o), 32'h0);
    ret_i = 1'b1;
    step();
    check("r2", pc_o, 32'h34);
    ret_i = 1'b1;
    step();
    check("r3", pc_o, 32'h24);
    ret_i = 1'b1;
    step();
    check("r4", pc_o, 32'h14);
    check("r4_empty", 32'(ras_empty_o), 32'h1);
    ret_i = 1'b1;
    step();
    check("r5_seq", pc_o, 32'h18);

    do_flush(32'h80);
    ret_i = 1'b1;
    step();
    check("ret_empty_seq", pc_o, 32'h84);
    do_call(32'h90);
    check("pre_br_empty", 32'(ras_empty_o), 32'h0);
    branch_i    = 1'b1;
    branch_pc_i = 32'h300;
    ret_i       = 1'b1;
    step();
    check("br_ret_pc", pc_o, 32'h300);
    check("br_ret_empty", 32'(ras_empty_o), 32'h0);
    ret_i = 1'b1;
    step();
    check("br_ret_pop", pc_o, 32'h88);
    check("br_ret_pop_empty",
          32'(ras_empty_o), 32'h1);

    do_flush(32'hFFFF_FFFC);
    check("wrap_pre", pc_o, 32'hFFFF_FFFC);
    step();
    check("wrap", pc_o, 32'h0);

    do_call(32'h400);
    check("pre_rst_pc", pc_o, 32'h400);
    check("pre_rst_empty", 32'(ras_empty_o), 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    check("async_pc", pc_o, 32'h0);
    check("async_empty", 32'(ras_empty_o), 32'h1);
    check("async_valid", 32'(pc_valid_o), 32'h0);
    #3;
    rst_i = 1'b1;
    step();
    check("post_rst", pc_o, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the basic fetch PC register. Sits at the head of the fetch stage.
- Adds over the basic PC: width and reset-vector parameters, internal sequential increment, pipeline flush redirect, branch redirect, and a circular return-address stack (RAS) for call/return prediction.
- Feeds the instruction memory address and the IF/ID pipeline register.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VEC, 0, value of pc_o on reset; XLEN bits wide.
- INC, 4, sequential increment added to pc_o.
- RAS_DEPTH, 4, number of RAS entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  run enable; while low, the PC does not advance.
- hold_i  in  1  stall from hazard detection; freezes the PC and the RAS.
- flush_i  in  1  redirect from a later stage (mispredict or exception).
- flush_pc_i  in  XLEN  target PC when flush_i is high.
- branch_i  in  1  taken branch or jump decoded this cycle.
- branch_pc_i  in  XLEN  target PC when branch_i is high.
- call_i  in  1  the current branch is a call; qualified by branch_i.
- ret_i  in  1  the current instruction is a return; predict its target from the RAS.
- pc_o  out  XLEN  current PC.
- pc_valid_o  out  1  high when pc_o is a live fetch address.
- ras_empty_o  out  1  RAS count = 0.
- ras_full_o  out  1  RAS count = RAS_DEPTH.

Behaviour:
- Reset (rst_i low, asynchronous): pc_o=RESET_VEC, pc_valid_o=0, RAS count=0, RAS top pointer=0, ras_empty_o=1, ras_full_o=0. RAS entry contents need not be cleared.
- Define adv = start_i & ~hold_i.
- pc_valid_o is registered. On each edge it takes the value of start_i. It is not affected by hold_i.
- Next-PC selection is evaluated on each rising edge, highest priority first:
  1. start_i=0: pc_o holds; RAS unchanged.
  2. flush_i=1: pc_o <= flush_pc_i. This applies even when hold_i=1 (a flush overrides a stall). RAS unchanged.
  3. hold_i=1: pc_o holds; RAS unchanged.
  4. branch_i=1: pc_o <= branch_pc_i.
  5. ret_i=1 and RAS non-empty: pc_o <= RAS[top]; pop.
  6. Otherwise: pc_o <= pc_o + INC, truncated to XLEN bits (wraps from max to 0).
- ret_i=1 with RAS empty: no pop; falls through to sequential pc_o + INC.
- RAS push: occurs when adv & ~flush_i & branch_i & call_i. Pushed value is pc_o + INC, truncated to XLEN bits.
  - Push with count < RAS_DEPTH: top++, entry written, count++.
  - Push with count = RAS_DEPTH: top++ modulo RAS_DEPTH, overwriting the oldest entry; count stays RAS_DEPTH.
- RAS pop: occurs only via selection case 5. Effect: top-- modulo RAS_DEPTH, count--.
- branch_i and ret_i both high: the branch wins; no pop.
- call_i without branch_i: ignored.
- ras_empty_o and ras_full_o are derived combinationally from the registered count. Latency 0 relative to count; they change on the edge that updates count.
- No combinational path from any input to pc_o. pc_o is a pure register; one-cycle redirect latency.
- Reset asserted mid-operation: immediate return to reset values, independent of the clock.

Test Plan:
- Reset, then start_i=1 for 3 cycles (RESET_VEC=0) -> pc_o = 0, 4, 8, 12. pc_valid_o=0 after reset, 1 from the first edge with start_i=1.
- hold_i=1 for 2 cycles at pc_o=0x10; then flush_i=1 with flush_pc_i=0x200 while hold_i=1 -> pc_o stays 0x10 for 2 cycles, then becomes 0x200.
- Call at pc_o=0x40 (branch_pc_i=0x100), then ret_i at 0x104 -> pc_o = 0x100, 0x104, 0x44. ras_empty_o goes 1 -> 0 -> 1.
- RAS_DEPTH=4; 5 nested calls from 0x0, 0x10, 0x20, 0x30, 0x40, then 5 returns -> returns give 0x44, 0x34, 0x24, 0x14; 5th return is sequential (+4). ras_full_o=1 after the 4th call.
- ret_i with empty RAS at 0x80 -> pc_o=0x84. Simultaneous branch_i (0x300) and ret_i -> pc_o=0x300, RAS count unchanged.
- pc_o=0xFFFFFFFC, advance -> pc_o=0x0. Assert rst_i mid-run between clock edges -> pc_o=RESET_VEC immediately and RAS reads empty.
